// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, CPU wishbone and memory wishbone signals around the arbiter
//  Names are seen from the arbiter: _i signals flow into it, _o signals flow out of it.
//  vid_req_i/vid_addr_i/vid_ak_o   video DMA request, burst start word address, per-beat ack
//  snd_req_i/snd_addr_i/snd_ak_o   sound DMA request, burst start word address, per-beat ack
//  dma_err_o                        DMA burst terminated by a memory error
//  cpu_*                            CPU wishbone single-beat port
//  mem_*                            external memory wishbone port
//  slave: the arbiter's view; master: the environment driving requests and memory responses
interface mem_arbiter_if;
    logic        vid_req_i;
    logic [21:0] vid_addr_i;
    logic        vid_ak_o;
    logic        snd_req_i;
    logic [21:0] snd_addr_i;
    logic        snd_ak_o;
    logic        dma_err_o;
    logic        cpu_cyc_i;
    logic        cpu_stb_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [21:0] cpu_addr_i;
    logic        cpu_ack_o;
    logic        cpu_err_o;
    logic        mem_cyc_o;
    logic        mem_stb_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [2:0]  mem_cti_o;
    logic [21:0] mem_addr_o;
    logic        mem_ack_i;
    logic        mem_err_i;
    modport slave (
        input  vid_req_i, vid_addr_i, snd_req_i, snd_addr_i,
        input  cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_addr_i,
        input  mem_ack_i, mem_err_i,
        output vid_ak_o, snd_ak_o, dma_err_o, cpu_ack_o, cpu_err_o,
        output mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_cti_o, mem_addr_o
    );
    modport master (
        output vid_req_i, vid_addr_i, snd_req_i, snd_addr_i,
        output cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_addr_i,
        output mem_ack_i, mem_err_i,
        input  vid_ak_o, snd_ak_o, dma_err_o, cpu_ack_o, cpu_err_o,
        input  mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_cti_o, mem_addr_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory wishbone port between video DMA, sound DMA and the CPU
//  clkcpu  system clock, rising edge
//  rst_n   asynchronous active-low reset
//  bus     mem_arbiter_if.slave: DMA requests/acks, CPU wishbone port, memory wishbone port
//  DMA grants run fixed BURST_LEN-beat incrementing bursts, CPU grants a single beat.
//  Priority video > sound > CPU, except that a CPU kept waiting through CPU_MAX_WAIT
//  DMA grants is served next. Every transaction is followed by one idle cycle.
module mem_arbiter #(
    parameter int BURST_LEN    = 4,
    parameter int CPU_MAX_WAIT = 3
) (
    input logic         clkcpu,
    input logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int BW = $clog2(BURST_LEN);
    localparam int WW = $clog2(CPU_MAX_WAIT + 1);
    typedef enum logic [1:0] {IDLE, VID, SND, CPU} state_t;
    state_t      state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [21:0] base_q, base_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        cyc_q;
    logic        cpu_req, dma, last, cpu_st;
    assign cpu_req = bus.cpu_cyc_i & bus.cpu_stb_i;
    assign dma     = (state_q == VID) || (state_q == SND);
    assign cpu_st  = state_q == CPU;
    assign last    = beat_q == BW'(BURST_LEN - 1);
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        base_d  = base_q;
        we_d    = we_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                wait_d = '0;
                if (cpu_req && wait_q == WW'(CPU_MAX_WAIT)) state_d = CPU;
                else if (bus.vid_req_i) begin
                    state_d = VID;
                    base_d  = bus.vid_addr_i;
                end else if (bus.snd_req_i) begin
                    state_d = SND;
                    base_d  = bus.snd_addr_i;
                end else if (cpu_req) state_d = CPU;
                if (state_d == CPU) begin
                    base_d = bus.cpu_addr_i;
                    we_d   = bus.cpu_we_i;
                    sel_d  = bus.cpu_sel_i;
                end else begin
                    we_d  = 1'b0;
                    sel_d = 4'hf;
                    // a DMA grant that overtakes a pending CPU request counts toward starvation
                    if (state_d != IDLE && cpu_req)
                        wait_d = (wait_q == WW'(CPU_MAX_WAIT)) ? wait_q : wait_q + 1'b1;
                end
            end
            VID, SND: begin
                if (bus.mem_err_i) state_d = IDLE;
                else if (bus.mem_ack_i) begin
                    state_d = last ? IDLE : state_q;
                    beat_d  = beat_q + 1'b1;
                end
            end
            CPU: begin
                // a dropped cpu_cyc_i abandons the access without forwarding anything
                if (bus.mem_ack_i || bus.mem_err_i || !bus.cpu_cyc_i) state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cyc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            base_q  <= base_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cyc_q   <= state_d != IDLE;
        end
    end
    assign bus.vid_ak_o   = (state_q == VID) & bus.mem_ack_i & ~bus.mem_err_i;
    assign bus.snd_ak_o   = (state_q == SND) & bus.mem_ack_i & ~bus.mem_err_i;
    assign bus.dma_err_o  = dma & bus.mem_err_i;
    assign bus.cpu_ack_o  = cpu_st & bus.cpu_cyc_i & bus.mem_ack_i & ~bus.mem_err_i;
    assign bus.cpu_err_o  = cpu_st & bus.cpu_cyc_i & bus.mem_err_i;
    assign bus.mem_cyc_o  = cyc_q;
    assign bus.mem_stb_o  = cyc_q;
    assign bus.mem_we_o   = cpu_st & we_q;
    assign bus.mem_sel_o  = cyc_q ? sel_q : 4'h0;
    assign bus.mem_cti_o  = dma ? (last ? 3'b111 : 3'b010) : 3'b000;
    assign bus.mem_addr_o = dma ? base_q + 22'(beat_q) : cpu_st ? base_q : 22'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written grant-order, starvation and reset sequences
module tb_mem_arbiter;
    localparam logic [21:0] VA = 22'h000100;
    localparam logic [21:0] SA = 22'h000200;
    localparam logic [21:0] CA = 22'h0abcde;
    logic clkcpu = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clkcpu = ~clkcpu;
    mem_arbiter_if bus();
    mem_arbiter #(.BURST_LEN(4), .CPU_MAX_WAIT(3)) dut (.clkcpu(clkcpu), .rst_n(rst_n), .bus(bus));
    int total = 0;
    int bad = 0;
    int grants[$];
    int gaps[$];
    typedef struct packed {
        logic        vr, sr, ak, er;
        logic [21:0] va, sa;
        logic        cy;
        logic [2:0]  ct;
        logic [21:0] ad;
        logic        vk, sk, de;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(input logic vr, sr, ak, er, input logic [21:0] va, sa,
                                input logic cy, input logic [2:0] ct, input logic [21:0] ad,
                                input logic vk, sk, de);
        vec_t v;
        v.vr = vr; v.sr = sr; v.ak = ak; v.er = er; v.va = va; v.sa = sa;
        v.cy = cy; v.ct = ct; v.ad = ad; v.vk = vk; v.sk = sk; v.de = de;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask
    function automatic int at(input int k);
        return (grants.size() > k) ? grants[k] : -1;
    endfunction
    task automatic watch(input bit hold_vid);
        bit prev = 1'b0;
        bit first = 1'b1;
        bit done = 1'b0;
        int idle = 0;
        int code;
        grants.delete();
        gaps.delete();
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clkcpu);
            #1;
            if (bus.mem_cyc_o && !prev) begin
                code = (bus.mem_addr_o == VA) ? 1 : (bus.mem_addr_o == SA) ? 2 : (bus.mem_addr_o == CA) ? 3 : 0;
                grants.push_back(code);
                if (!first) gaps.push_back(idle);
                first = 1'b0;
                if (code == 3) begin
                    chk("cpu_we", bus.mem_we_o, 1);
                    chk("cpu_sel", bus.mem_sel_o, 4'h5);
                    chk("cpu_cti", bus.mem_cti_o, 3'b000);
                end
            end
            idle = bus.mem_cyc_o ? 0 : idle + 1;
            prev = bus.mem_cyc_o;
            if (bus.vid_ak_o && !hold_vid) bus.vid_req_i = 1'b0;
            if (bus.snd_ak_o) bus.snd_req_i = 1'b0;
            if (bus.cpu_ack_o) begin
                bus.cpu_cyc_i = 1'b0;
                bus.cpu_stb_i = 1'b0;
                bus.vid_req_i = 1'b0;
                done = 1'b1;
            end
        end
        chk("watch_cpu_done", done, 1);
        repeat (3) @(negedge clkcpu);
    endtask
    initial begin
        bus.vid_req_i = 0; bus.vid_addr_i = 0; bus.snd_req_i = 0; bus.snd_addr_i = 0;
        bus.cpu_cyc_i = 0; bus.cpu_stb_i = 0; bus.cpu_we_i = 0; bus.cpu_sel_i = 0; bus.cpu_addr_i = 0;
        bus.mem_ack_i = 0; bus.mem_err_i = 0;
        // 1: video burst at 0x001000 with one wait state; request dropped mid-burst
        tbl.push_back(mk(1,0,0,0, 22'h001000,0, 0,0,0,       0,0,0));
        tbl.push_back(mk(1,0,1,0, 22'h001000,0, 1,2,22'h001000, 1,0,0));
        tbl.push_back(mk(0,0,0,0, 22'h0,0,      1,2,22'h001001, 0,0,0));
        tbl.push_back(mk(0,0,1,0, 22'h0,0,      1,2,22'h001001, 1,0,0));
        tbl.push_back(mk(0,0,1,0, 22'h0,0,      1,2,22'h001002, 1,0,0));
        tbl.push_back(mk(0,0,1,0, 22'h0,0,      1,7,22'h001003, 1,0,0));
        tbl.push_back(mk(0,0,1,0, 22'h0,0,      0,0,0,       0,0,0));
        tbl.push_back(mk(0,0,0,0, 22'h0,0,      0,0,0,       0,0,0));
        // 4: sound burst wrapping the 22-bit address space
        tbl.push_back(mk(0,1,0,0, 0,22'h3ffffe, 0,0,0,       0,0,0));
        tbl.push_back(mk(0,1,1,0, 0,22'h3ffffe, 1,2,22'h3ffffe, 0,1,0));
        tbl.push_back(mk(0,0,1,0, 0,22'h0,      1,2,22'h3fffff, 0,1,0));
        tbl.push_back(mk(0,0,1,0, 0,22'h0,      1,2,22'h000000, 0,1,0));
        tbl.push_back(mk(0,0,1,0, 0,22'h0,      1,7,22'h000001, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,22'h0,      0,0,0,       0,0,0));
        // 5: error with simultaneous ack on beat 2 ends the burst, no ak that cycle
        tbl.push_back(mk(1,0,0,0, 22'h002000,0, 0,0,0,       0,0,0));
        tbl.push_back(mk(1,0,1,0, 22'h002000,0, 1,2,22'h002000, 1,0,0));
        tbl.push_back(mk(0,0,1,0, 22'h002000,0, 1,2,22'h002001, 1,0,0));
        tbl.push_back(mk(0,0,1,1, 22'h002000,0, 1,2,22'h002002, 0,0,1));
        tbl.push_back(mk(0,0,0,0, 22'h002000,0, 0,0,0,       0,0,0));
        tbl.push_back(mk(0,0,0,0, 22'h002000,0, 0,0,0,       0,0,0));
        repeat (2) @(negedge clkcpu);
        #1;
        chk("rst_cyc", bus.mem_cyc_o, 0);
        chk("rst_stb", bus.mem_stb_o, 0);
        chk("rst_addr", bus.mem_addr_o, 0);
        chk("rst_sel", bus.mem_sel_o, 0);
        chk("rst_cti", bus.mem_cti_o, 0);
        chk("rst_we", bus.mem_we_o, 0);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clkcpu);
            bus.vid_req_i = tbl[i].vr; bus.snd_req_i = tbl[i].sr;
            bus.mem_ack_i = tbl[i].ak; bus.mem_err_i = tbl[i].er;
            bus.vid_addr_i = tbl[i].va; bus.snd_addr_i = tbl[i].sa;
            #1;
            chk($sformatf("row%0d_cyc", i), bus.mem_cyc_o, tbl[i].cy);
            chk($sformatf("row%0d_vak", i), bus.vid_ak_o, tbl[i].vk);
            chk($sformatf("row%0d_sak", i), bus.snd_ak_o, tbl[i].sk);
            chk($sformatf("row%0d_derr", i), bus.dma_err_o, tbl[i].de);
            if (tbl[i].cy) begin
                chk($sformatf("row%0d_cti", i), bus.mem_cti_o, tbl[i].ct);
                chk($sformatf("row%0d_addr", i), bus.mem_addr_o, tbl[i].ad);
                chk($sformatf("row%0d_sel", i), bus.mem_sel_o, 4'hf);
                chk($sformatf("row%0d_we", i), bus.mem_we_o, 0);
            end
        end
        // 2: all three requesters at once
        bus.vid_addr_i = VA; bus.snd_addr_i = SA; bus.cpu_addr_i = CA;
        bus.cpu_we_i = 1'b1; bus.cpu_sel_i = 4'h5; bus.mem_ack_i = 1'b1; bus.mem_err_i = 1'b0;
        bus.vid_req_i = 1'b1; bus.snd_req_i = 1'b1; bus.cpu_cyc_i = 1'b1; bus.cpu_stb_i = 1'b1;
        watch(1'b0);
        chk("order_n", grants.size(), 3);
        chk("order0", at(0), 1);
        chk("order1", at(1), 2);
        chk("order2", at(2), 3);
        for (int k = 0; k < gaps.size(); k++) chk($sformatf("order_gap%0d", k), gaps[k], 1);
        // 3: video held, CPU forced in after three bursts, twice
        for (int r = 0; r < 2; r++) begin
            bus.vid_req_i = 1'b1; bus.cpu_cyc_i = 1'b1; bus.cpu_stb_i = 1'b1;
            watch(1'b1);
            chk($sformatf("starve%0d_n", r), grants.size(), 4);
            for (int k = 0; k < 3; k++) chk($sformatf("starve%0d_vid%0d", r, k), at(k), 1);
            chk($sformatf("starve%0d_cpu", r), at(3), 3);
            for (int k = 0; k < gaps.size(); k++) chk($sformatf("starve%0d_gap%0d", r, k), gaps[k], 1);
        end
        // 6: asynchronous reset on beat 1, then a fresh burst from beat 0
        bus.vid_addr_i = VA; bus.vid_req_i = 1'b1; bus.mem_ack_i = 1'b1;
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 20 && !hit; c++) begin
                @(negedge clkcpu);
                #1;
                hit = bus.mem_cyc_o && bus.mem_addr_o == VA + 22'h1;
            end
            chk("rst6_reach_beat1", hit, 1);
        end
        rst_n = 1'b0;
        #1;
        chk("rst6_cyc", bus.mem_cyc_o, 0);
        chk("rst6_vak", bus.vid_ak_o, 0);
        chk("rst6_addr", bus.mem_addr_o, 0);
        @(negedge clkcpu);
        rst_n = 1'b1;
        @(negedge clkcpu);
        #1;
        chk("rst6_regrant", bus.mem_cyc_o, 1);
        chk("rst6_addr0", bus.mem_addr_o, VA);
        chk("rst6_cti0", bus.mem_cti_o, 3'b010);
        bus.vid_req_i = 1'b0;
        repeat (6) @(negedge clkcpu);
        #1;
        chk("rst6_done", bus.mem_cyc_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
